alu_bist_driver: RTL

Hardware initiator for the ALU interface: drives pseudo-random operand/opcode vectors into the wrapped ALU, compresses returned results into a MISR signature, compares it to a golden value. Sits beside the ALU wrapper in place of the testbench program, giving a self-test on silicon/FPGA with a single start/done handshake.

---
 rtl/alu_bist_pkg.sv | 23 ++
 rtl/alu_bist_misr.sv | 28 ++
 rtl/alu_bist_driver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_bist_pkg.sv
// Shared types, polynomials and step functions for the ALU self-test driver.
package alu_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Galois taps for x^64+x^63+x^61+x^60+1, right-shifting form.
    localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;
    localparam logic [63:0] MISR_POLY = 64'h0000_0000_0000_001B;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 64'd0);
    endfunction

    function automatic logic [63:0] misr_step(input logic [63:0] sig, input logic [63:0] res);
        return {sig[62:0], 1'b0} ^ (sig[63] ? MISR_POLY : 64'd0) ^ res;
    endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// Multiple-input signature register: shift-left with feedback, XOR in the result.
module alu_bist_misr
    import alu_bist_pkg::*;
#(
    parameter int RES_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [RES_W-1:0] din,
    output logic [RES_W-1:0] sig
);

    localparam logic [RES_W-1:0] POLY = MISR_POLY[RES_W-1:0];

    // Signature register; clear takes priority so a new run never inherits old state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[RES_W-2:0], 1'b0} ^ (sig[RES_W-1] ? POLY : '0) ^ din;
        end
    end

endmodule

// File: rtl/alu_bist_driver.sv
// ALU built-in self-test initiator: LFSR vectors out, MISR-compressed results in.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | after reset, waiting for start
//  ST_RUN   | seed loaded; one vector launched per cycle until all issued
//  ST_DRAIN | no launches; waiting for in-flight results to be absorbed
//  ST_DONE  | done high, pass valid; start begins a fresh run
module alu_bist_driver
    import alu_bist_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          RES_W     = 64,
    parameter int          OP_W      = 3,
    parameter int          NUM_OPS   = 8,
    parameter int          N_VECTORS = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [63:0] SEED      = 64'hACE1_2468_BDF1_3579
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [RES_W-1:0] golden_sig,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [RES_W-1:0] alu_res,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [RES_W-1:0] signature
);

    localparam int CNT_W = (N_VECTORS > 1) ? $clog2(N_VECTORS) : 1;

    state_t             state, next_state;
    logic               launch;
    logic               load;
    logic [63:0]        lfsr;
    logic [CNT_W-1:0]   remain;
    logic [OP_W-1:0]    op_cnt;
    logic [LATENCY-1:0] vld_sr;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; the seed is loaded on the edge that accepts start.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        load       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_RUN;
                    load       = 1'b1;
                end
            end
            ST_RUN: begin
                launch = 1'b1;
                if (remain == '0) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (vld_sr == '0) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    next_state = ST_RUN;
                    load       = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Vector generation: remain counts down to the last launch; outputs idle at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr   <= SEED;
            remain <= '0;
            op_cnt <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else begin
            if (load) begin
                lfsr   <= SEED;
                remain <= CNT_W'(N_VECTORS - 1);
                op_cnt <= '0;
            end else if (launch) begin
                lfsr   <= lfsr_step(lfsr);
                remain <= remain - CNT_W'(1);
                op_cnt <= (op_cnt == OP_W'(NUM_OPS - 1)) ? '0 : op_cnt + OP_W'(1);
            end
            alu_a  <= launch ? lfsr[WIDTH-1:0]     : '0;
            alu_b  <= launch ? lfsr[WIDTH+31:32]   : '0;
            alu_op <= launch ? op_cnt              : '0;
        end
    end

    // Launch tracker; the top bit marks a result arriving this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | LATENCY'(launch);
        end
    end

    // busy covers launch and drain cycles only, so it drops as done rises;
    // pass is captured against the final signature on the way into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            pass <= 1'b0;
        end else begin
            busy <= (state == ST_RUN || state == ST_DRAIN) && (next_state != ST_DONE);
            if (next_state != ST_DONE) begin
                pass <= 1'b0;
            end else if (state == ST_DRAIN) begin
                pass <= (signature == golden_sig);
            end
        end
    end

    alu_bist_misr #(
        .RES_W (RES_W)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (load),
        .en    (vld_sr[LATENCY-1]),
        .din   (alu_res),
        .sig   (signature)
    );

endmodule
